// File: rtl/div_share_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_share_sched_pkg
// Brief    : Shared encodings and constants for the divider-sharing scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package div_share_sched_pkg;

    localparam int          c_datalength = 32;
    localparam logic [31:0] c_qnan       = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND_A = 3'd1,
        S_SEND_B = 3'd2,
        S_WAIT_Z = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_share_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational rotating-priority pick of the first request at or after Ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import div_share_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] Req,
    input  logic [IW-1:0]   Ptr,
    output logic [NREQ-1:0] Grant_next,
    output logic [IW-1:0]   Index
);

    logic [NREQ-1:0] w_rot;
    logic            w_found;
    int              w_sum;

    always_comb begin
        // Rotate so bit 0 is the lane at Ptr; the winner's offset is then added back.
        w_rot   = NREQ'({Req, Req} >> Ptr);
        w_found = 1'b0;
        w_sum   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = int'(Ptr) + k;
            end
        end
        if (w_sum >= NREQ) begin
            w_sum = w_sum - NREQ;
        end
        Index = IW'(w_sum);
        for (int i = 0; i < NREQ; i++) begin
            Grant_next[i] = w_found && (w_sum == i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : div_share_sched
// Brief    : Round-robin time-sharing of one FP divider across NREQ lanes.
//            Define DIV_TIMEOUT_EN to add the WAIT_Z watchdog and Err output.
// Revision : 1.0 - initial release
// ============================================================================
module div_share_sched
    import div_share_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATALENGTH = c_datalength,
    parameter int TIMEOUT    = 255
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NREQ-1:0]            Req,
    input  logic [NREQ*DATALENGTH-1:0] OpA,
    input  logic [NREQ*DATALENGTH-1:0] OpB,
    output logic [NREQ-1:0]            Grant,
    output logic [NREQ-1:0]            Done,
    output logic [DATALENGTH-1:0]      Result,
    output logic                       Busy,
    output logic                       Err,
    output logic [DATALENGTH-1:0]      DivA,
    output logic [DATALENGTH-1:0]      DivB,
    output logic                       DivA_Stb,
    output logic                       DivB_Stb,
    input  logic                       DivA_Ack,
    input  logic                       DivB_Ack,
    input  logic [DATALENGTH-1:0]      DivZ,
    input  logic                       DivZ_Stb,
    output logic                       DivZ_Ack
);

    localparam int IW = idx_width(NREQ);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_arb_idx;
    logic [NREQ-1:0]       w_arb_grant;
    logic [NREQ-1:0]       r_grant;
    logic [NREQ-1:0]       r_done;
    logic [DATALENGTH-1:0] r_result;
    logic [DATALENGTH-1:0] r_diva;
    logic [DATALENGTH-1:0] r_divb;
    logic                  r_busy;
    logic                  r_stba;
    logic                  r_stbb;
    logic                  r_zack;
    logic                  w_timeout;
    logic [DATALENGTH-1:0] w_opa [NREQ];
    logic [DATALENGTH-1:0] w_opb [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_opa[gi] = OpA[gi*DATALENGTH +: DATALENGTH];
        assign w_opb[gi] = OpB[gi*DATALENGTH +: DATALENGTH];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .Req        (Req),
        .Ptr        (r_ptr),
        .Grant_next (w_arb_grant),
        .Index      (w_arb_idx)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (|Req)                   w_state_nxt = S_SEND_A;
            S_SEND_A: if (DivA_Ack)               w_state_nxt = S_SEND_B;
            S_SEND_B: if (DivB_Ack)               w_state_nxt = S_WAIT_Z;
            S_WAIT_Z: if (DivZ_Stb || w_timeout)  w_state_nxt = S_DONE;
            S_DONE:                               w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes and Busy are registered from the next state so each output comes straight from a flop.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_ptr    <= '0;
            r_idx    <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_diva   <= '0;
            r_divb   <= '0;
            r_busy   <= 1'b0;
            r_stba   <= 1'b0;
            r_stbb   <= 1'b0;
            r_zack   <= 1'b0;
        end else begin
            r_done <= '0;
            r_busy <= (w_state_nxt != S_IDLE);
            r_stba <= (w_state_nxt == S_SEND_A);
            r_stbb <= (w_state_nxt == S_SEND_B);
            r_zack <= (r_state == S_WAIT_Z) && DivZ_Stb;
            case (r_state)
                S_IDLE: begin
                    if (|Req) begin
                        r_grant <= w_arb_grant;
                        r_idx   <= w_arb_idx;
                        r_diva  <= w_opa[w_arb_idx];
                        r_divb  <= w_opb[w_arb_idx];
                    end
                end
                S_WAIT_Z: begin
                    if (DivZ_Stb) begin
                        r_result <= DivZ;
                    end else if (w_timeout) begin
                        r_result <= DATALENGTH'(c_qnan);
                    end
                end
                S_DONE: begin
                    r_done  <= r_grant;
                    r_grant <= '0;
                    r_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_TIMEOUT_EN
    localparam int WW = (idx_width(TIMEOUT + 1) > 8) ? idx_width(TIMEOUT + 1) : 8;

    logic [WW-1:0] r_wdog;
    logic          r_tout;
    logic          r_err;

    assign w_timeout = (r_wdog == WW'(TIMEOUT - 1));

    // r_tout remembers that this op ended by expiry so Err can pulse alongside Done.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_wdog <= '0;
            r_tout <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if ((r_state == S_WAIT_Z) && !DivZ_Stb) begin
                r_wdog <= r_wdog + 1'b1;
                if (w_timeout) begin
                    r_tout <= 1'b1;
                end
            end else begin
                r_wdog <= '0;
            end
            if (r_state == S_DONE) begin
                r_err  <= r_tout;
                r_tout <= 1'b0;
            end
        end
    end

    assign Err = r_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign Err              = 1'b0;
`endif

    assign Grant    = r_grant;
    assign Done     = r_done;
    assign Result   = r_result;
    assign Busy     = r_busy;
    assign DivA     = r_diva;
    assign DivB     = r_divb;
    assign DivA_Stb = r_stba;
    assign DivB_Stb = r_stbb;
    assign DivZ_Ack = r_zack;

endmodule
`default_nettype wire

// File: tb/tb_div_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_share_sched
// Brief    : Scoreboard bench for div_share_sched with a behavioural handshake divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_share_sched;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] T_A [5] = '{32'h40C00000, 32'h3F800000, 32'h41000000, 32'h3F800000, 32'h41100000};
    localparam logic [31:0] T_B [5] = '{32'h40000000, 32'h40000000, 32'h40800000, 32'h40800000, 32'h40400000};
    localparam logic [31:0] T_Z [5] = '{32'h40400000, 32'h3F000000, 32'h40000000, 32'h3E800000, 32'h40400000};

    typedef struct packed {
        logic [3:0]  oh;
        logic [31:0] z;
    } exp_t;

    logic         Clock, Reset;
    logic [3:0]   Req, Grant, Done;
    logic [127:0] OpA, OpB;
    logic [31:0]  Result, DivA, DivB, DivZ;
    logic         Busy, Err, DivA_Stb, DivB_Stb, DivA_Ack, DivB_Ack, DivZ_Stb, DivZ_Ack;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [3:0] sticky = '0;

    div_share_sched #(.NREQ(4), .DATALENGTH(32), .TIMEOUT(10)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .OpA(OpA), .OpB(OpB),
        .Grant(Grant), .Done(Done), .Result(Result), .Busy(Busy), .Err(Err),
        .DivA(DivA), .DivB(DivB), .DivA_Stb(DivA_Stb), .DivB_Stb(DivB_Stb),
        .DivA_Ack(DivA_Ack), .DivB_Ack(DivB_Ack), .DivZ(DivZ), .DivZ_Stb(DivZ_Stb),
        .DivZ_Ack(DivZ_Ack)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Behavioural divider: configurable ack / result delays, optional withheld result.
    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
        div_model = 32'hBAD0_0000 ^ a ^ b;
        for (int i = 0; i < 5; i++) begin
            if (a == T_A[i] && b == T_B[i]) div_model = T_Z[i];
        end
    endfunction

    int          ack_dly = 0;
    int          z_dly   = 0;
    bit          z_hold  = 1'b0;
    int          a_cnt, b_cnt, z_cnt;
    logic        m_zpend;
    logic [31:0] m_a, m_z;

    assign DivA_Ack = DivA_Stb && (a_cnt >= ack_dly);
    assign DivB_Ack = DivB_Stb && (b_cnt >= ack_dly);
    assign DivZ_Stb = m_zpend && !z_hold && (z_cnt >= z_dly);
    assign DivZ     = m_zpend ? m_z : 32'h0;

    always @(posedge Clock) begin
        if (!Reset) begin
            m_zpend <= 1'b0;
            a_cnt   <= 0;
            b_cnt   <= 0;
            z_cnt   <= 0;
            m_a     <= '0;
            m_z     <= '0;
        end else begin
            a_cnt <= (DivA_Stb && !DivA_Ack) ? a_cnt + 1 : 0;
            b_cnt <= (DivB_Stb && !DivB_Ack) ? b_cnt + 1 : 0;
            if (DivA_Stb && DivA_Ack) m_a <= DivA;
            if (DivB_Stb && DivB_Ack) begin
                m_zpend <= 1'b1;
                m_z     <= div_model(m_a, DivB);
                z_cnt   <= 0;
            end else if (m_zpend) begin
                if (DivZ_Stb && DivZ_Ack) m_zpend <= 1'b0;
                else z_cnt <= z_cnt + 1;
            end
        end
    end

    task automatic set_lane_ops();
        for (int i = 0; i < 4; i++) begin
            OpA[i*32 +: 32] = T_A[i];
            OpB[i*32 +: 32] = T_B[i];
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b0;
        Req   = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    // Waits for a Done pulse; retires served non-sticky requests the way a lane would.
    task automatic wait_done(input int budget, output logic [3:0] d, output logic [31:0] r,
                             output logic e, output int cyc, output int busy_bad, output bit to);
        d = '0; r = '0; e = 1'b0; cyc = 0; busy_bad = 0; to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge Clock);
            cyc++;
            if (Busy !== (|Grant)) busy_bad++;
            if (Done !== 4'b0) begin
                d = Done; r = Result; e = Err; to = 1'b0;
                Req = Req & ~(Done & ~sticky);
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (Grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", Grant); end
        n_vec++; if (Done !== 4'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0000", Done); end
        n_vec++; if (Result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", Result); end
        n_vec++; if ({Busy, Err, DivA_Stb, DivB_Stb, DivZ_Ack} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {Busy, Err, DivA_Stb, DivB_Stb, DivZ_Ack});
        end
        n_vec++; if ({DivA, DivB} !== 64'h0) begin n_bad++; $display("FAIL reset_operands: got %h want 0", {DivA, DivB}); end
        @(negedge Clock);
        n_vec++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", Busy); end
    endtask

    task automatic test_single();
        logic [3:0] d; logic [31:0] r; logic e; int cyc, bb; bit to; exp_t x;
        Req = 4'b0001;
        sb.push_back('{4'b0001, T_Z[0]});
        @(negedge Clock);
        n_vec++; if ({DivA_Stb, Grant, DivA} !== {1'b1, 4'b0001, T_A[0]}) begin
            n_bad++; $display("FAIL single_first_cycle: got stb=%b grant=%b a=%h want 1 0001 %h", DivA_Stb, Grant, DivA, T_A[0]);
        end
        wait_done(20, d, r, e, cyc, bb, to);
        x = sb.pop_front();
        n_vec++; if (to) begin n_bad++; $display("FAIL single_timeout: no Done within 20 cycles"); end
        n_vec++; if ({d, r} !== {x.oh, x.z}) begin n_bad++; $display("FAIL single_result: got %b/%h want %b/%h", d, r, x.oh, x.z); end
        n_vec++; if (cyc !== 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", cyc); end
        n_vec++; if ({e, Grant} !== 5'b0) begin n_bad++; $display("FAIL single_err_grant: got %b/%b want 0/0000", e, Grant); end
        @(negedge Clock);
        n_vec++; if (Done !== 4'b0) begin n_bad++; $display("FAIL single_done_width: got %b want 0000", Done); end
    endtask

    task automatic test_all_lanes();
        logic [3:0] d; logic [31:0] r; logic e; int cyc, bb; bit to; exp_t x;
        apply_reset();
        Req = 4'b1111;
        for (int i = 0; i < 4; i++) sb.push_back('{4'(1 << i), T_Z[i]});
        for (int i = 0; i < 4; i++) begin
            wait_done(20, d, r, e, cyc, bb, to);
            x = sb.pop_front();
            n_vec++; if (to || {d, r} !== {x.oh, x.z}) begin
                n_bad++; $display("FAIL all_lanes_op%0d: got %b/%h want %b/%h", i, d, r, x.oh, x.z);
            end
            n_vec++; if (cyc !== 5 || bb !== 0) begin
                n_bad++; $display("FAIL all_lanes_b2b%0d: got %0d cycles, %0d busy errs want 5, 0", i, cyc, bb);
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] d; logic [31:0] r; logic e; int cyc, bb; bit to; exp_t x; bit served;
        served = 1'b0;
        sticky = 4'b0011;
        Req    = 4'b0111;
        for (int i = 0; i < 3; i++) sb.push_back('{4'(1 << i), T_Z[i]});
        for (int i = 0; i < 3 && !served; i++) begin
            wait_done(20, d, r, e, cyc, bb, to);
            x = sb.pop_front();
            n_vec++; if (to || {d, r} !== {x.oh, x.z}) begin
                n_bad++; $display("FAIL fairness_op%0d: got %b/%h want %b/%h", i, d, r, x.oh, x.z);
            end
            if (d == 4'b0100) served = 1'b1;
        end
        sticky = '0;
        Req    = '0;
        n_vec++; if (!served) begin n_bad++; $display("FAIL fairness_lane2: got not served want served within 3 ops"); end
    endtask

    task automatic test_ack_delay();
        logic [3:0] d; logic [31:0] r; int ca, cb, cz; bit got; exp_t x;
        ca = 0; cb = 0; cz = 0; got = 1'b0; d = '0; r = '0;
        ack_dly = 3; z_dly = 2;
        Req = 4'b0010;
        sb.push_back('{4'b0010, T_Z[1]});
        for (int c = 0; c < 60; c++) begin
            @(negedge Clock);
            if (DivA_Stb) ca++;
            if (DivB_Stb) cb++;
            if (DivZ_Ack) cz++;
            if (Grant !== 4'b0) OpA[32 +: 32] = T_A[4];
            if (Done !== 4'b0) begin d = Done; r = Result; got = 1'b1; Req = '0; break; end
        end
        x = sb.pop_front();
        n_vec++; if (!got || {d, r} !== {x.oh, x.z}) begin
            n_bad++; $display("FAIL delay_result: got %b/%h want %b/%h", d, r, x.oh, x.z);
        end
        n_vec++; if ({ca, cb, cz} !== {32'd4, 32'd4, 32'd1}) begin
            n_bad++; $display("FAIL delay_handshake: got a=%0d b=%0d zack=%0d want 4 4 1", ca, cb, cz);
        end
        ack_dly = 0; z_dly = 0;
        set_lane_ops();
    endtask

    task automatic test_req_drop();
        logic [3:0] d; logic [31:0] r; logic e; int cyc, bb; bit to; exp_t x;
        Req = 4'b0100;
        sb.push_back('{4'b0100, T_Z[2]});
        @(negedge Clock);
        Req = '0;
        wait_done(20, d, r, e, cyc, bb, to);
        x = sb.pop_front();
        n_vec++; if (to || {d, r} !== {x.oh, x.z}) begin
            n_bad++; $display("FAIL req_drop: got %b/%h want %b/%h", d, r, x.oh, x.z);
        end
    endtask

    task automatic test_reset_midop();
        logic [3:0] d; logic [31:0] r; logic e; int cyc, bb, quiet; bit to, ok; exp_t x;
        ok = 1'b0; quiet = 0;
        z_hold = 1'b1;
        Req    = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            if (DivB_Stb && DivB_Ack) begin ok = 1'b1; break; end
        end
        n_vec++; if (!ok) begin n_bad++; $display("FAIL midop_reach_waitz: got no B handshake want one"); end
        repeat (2) @(negedge Clock);
`ifndef DIV_TIMEOUT_EN
        repeat (20) begin
            @(negedge Clock);
            if (Done !== 4'b0 || Err !== 1'b0 || Grant !== 4'b1000) quiet++;
        end
        n_vec++; if (quiet != 0) begin n_bad++; $display("FAIL waitz_indefinite: got %0d bad cycles want 0", quiet); end
`endif
        Reset = 1'b0;
        @(negedge Clock);
        n_vec++; if ({Grant, Done, Busy, Err, DivA_Stb, DivB_Stb, DivZ_Ack} !== 13'b0 || {Result, DivA, DivB} !== 96'h0) begin
            n_bad++; $display("FAIL midop_reset: got g=%b d=%b busy=%b res=%h want all zero", Grant, Done, Busy, Result);
        end
        Reset  = 1'b1;
        Req    = '0;
        z_hold = 1'b0;
        quiet  = 0;
        repeat (5) begin
            @(negedge Clock);
            if (Done !== 4'b0) quiet++;
        end
        n_vec++; if (quiet != 0) begin n_bad++; $display("FAIL midop_no_done: got %0d Done cycles want 0", quiet); end
        Req = 4'b1010;
        sb.push_back('{4'b0010, T_Z[1]});
        sb.push_back('{4'b1000, T_Z[3]});
        for (int i = 0; i < 2; i++) begin
            wait_done(20, d, r, e, cyc, bb, to);
            x = sb.pop_front();
            n_vec++; if (to || {d, r} !== {x.oh, x.z}) begin
                n_bad++; $display("FAIL midop_after_reset%0d: got %b/%h want %b/%h", i, d, r, x.oh, x.z);
            end
        end
    endtask

`ifdef DIV_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] d; logic [31:0] r; logic e; int cyc, bb; bit to, ok; exp_t x;
        ok = 1'b0;
        z_hold = 1'b1;
        Req    = 4'b0001;
        sb.push_back('{4'b0001, QNAN});
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            if (DivB_Stb && DivB_Ack) begin ok = 1'b1; break; end
        end
        wait_done(40, d, r, e, cyc, bb, to);
        x = sb.pop_front();
        n_vec++; if (!ok || to || {d, r, e} !== {x.oh, x.z, 1'b1}) begin
            n_bad++; $display("FAIL timeout_result: got %b/%h err=%b want %b/%h err=1", d, r, e, x.oh, x.z);
        end
        n_vec++; if (cyc !== 12) begin n_bad++; $display("FAIL timeout_latency: got %0d want 12", cyc); end
        @(negedge Clock);
        n_vec++; if ({Err, DivZ_Ack} !== 2'b0) begin n_bad++; $display("FAIL timeout_err_width: got %b want 00", {Err, DivZ_Ack}); end
        z_hold = 1'b0;
        apply_reset();
    endtask
`endif

    initial begin
        Reset = 1'b0;
        Req   = '0;
        OpA   = '0;
        OpB   = '0;
        set_lane_ops();
        test_reset();
        test_single();
        test_all_lanes();
        test_fairness();
        test_ack_delay();
        test_req_drop();
        test_reset_midop();
`ifdef DIV_TIMEOUT_EN
        test_timeout();
`endif
        n_vec++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
